bram_port_master: RTL

//  Master-side driver for a BramPort: turns a valid/ready request stream into BRAM port cycles.

---
 rtl/bram_port_master.sv | 128 ++++++++++++
 1 files changed

// File: rtl/bram_port_master.sv
// bram_port_master
//   Master-side driver for a BRAM port. Accepts a valid/ready request stream,
//   issues each request to the BRAM in the accept cycle, and returns read
//   data on a valid/ready response stream in request order. Read data is
//   captured after RD_LATENCY cycles into a RESP_DEPTH-entry response FIFO.
//   A credit counter reserves a FIFO slot for every read in flight, so no
//   response is ever lost under backpressure.
//
// Ports
//   Clk_CI, Rst_RI                  clock, asynchronous active-high reset
//   Req_Valid_SI / Req_Ready_SO     request handshake
//   Req_Addr_DI, Req_WrData_DI      request address / write data
//   Req_WrEn_SI                     byte strobes, all-zero means read
//   Resp_Valid_SO / Resp_Ready_SI   read response handshake
//   Resp_RdData_DO                  read response data (head of FIFO)
//   Bram_*                          BRAM port (clock/reset forwarded)
module bram_port_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned RESP_DEPTH = 2
) (
  input  logic                    Clk_CI,
  input  logic                    Rst_RI,
  input  logic                    Req_Valid_SI,
  output logic                    Req_Ready_SO,
  input  logic [ADDR_WIDTH-1:0]   Req_Addr_DI,
  input  logic [DATA_WIDTH-1:0]   Req_WrData_DI,
  input  logic [DATA_WIDTH/8-1:0] Req_WrEn_SI,
  output logic                    Resp_Valid_SO,
  input  logic                    Resp_Ready_SI,
  output logic [DATA_WIDTH-1:0]   Resp_RdData_DO,
  output logic                    Bram_Clk_CO,
  output logic                    Bram_Rst_RO,
  output logic                    Bram_En_SO,
  output logic [ADDR_WIDTH-1:0]   Bram_Addr_SO,
  output logic [DATA_WIDTH-1:0]   Bram_WrData_DO,
  output logic [DATA_WIDTH/8-1:0] Bram_WrEn_SO,
  input  logic [DATA_WIDTH-1:0]   Bram_RdData_DI
);

  localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
  localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  logic [CW-1:0]         used;
  logic [CW-1:0]         fifo_cnt;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_q [RESP_DEPTH];
  logic [RD_LATENCY-1:0] rd_pipe;
  logic [RD_LATENCY:0]   pipe_next;
  logic                  acc;
  logic                  rd_acc;
  logic                  push;
  logic                  pop;

  assign Bram_Clk_CO = Clk_CI;
  assign Bram_Rst_RO = Rst_RI;

  // Ready depends only on registered credits and reset, never on the
  // response side or on Req_Valid_SI.
  assign Req_Ready_SO = !Rst_RI && (used < CW'(RESP_DEPTH));
  assign acc          = Req_Valid_SI && Req_Ready_SO;
  assign rd_acc       = acc && (Req_WrEn_SI == '0);

  assign Bram_En_SO     = acc;
  assign Bram_Addr_SO   = Req_Addr_DI;
  assign Bram_WrData_DO = Req_WrData_DI;
  assign Bram_WrEn_SO   = acc ? Req_WrEn_SI : '0;

  assign Resp_Valid_SO  = (fifo_cnt != '0);
  assign Resp_RdData_DO = fifo_q[rd_ptr];
  assign pop            = Resp_Valid_SO && Resp_Ready_SI;
  assign push           = rd_pipe[RD_LATENCY-1];

  // Concatenating the new tag below the pipe keeps the shift uniform even
  // when RD_LATENCY is 1.
  assign pipe_next = {rd_pipe, rd_acc};

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe <= pipe_next[RD_LATENCY-1:0];
    end
  end

  // Credits: one per read between accept and pop.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      used <= '0;
    end else begin
      case ({rd_acc, pop})
        2'b10:   used <= used + CW'(1);
        2'b01:   used <= used - CW'(1);
        default: used <= used;
      endcase
    end
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(RESP_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(RESP_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge Clk_CI) begin
    if (push) begin
      fifo_q[wr_ptr] <= Bram_RdData_DI;
    end
  end

endmodule
